// File: rtl/seq_alu_pkg.sv
// Shared types for the digit-serial ALU: controller states and {M,Cen} op decode.
package seq_alu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Operation codes, indexed as {M, Cen}
    localparam logic [1:0] XOR  = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] XNOR = 2'b10;
    localparam logic [1:0] SUB  = 2'b11;

endpackage

// File: rtl/seq_alu_digit_alu.sv
// One DIGIT-wide combinational ALU slice; the sequencer reuses it once per cycle.
module digit_alu
    import seq_alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             m,
    input  logic             cen,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT-1:0] t;
    logic [DIGIT:0]   full;

    assign t    = b ^ {DIGIT{m}};
    assign full = {1'b0, a} + {1'b0, t} + {{DIGIT{1'b0}}, cin};

    always_comb begin
        sum  = a ^ t;
        cout = 1'b0;
        cmsb = 1'b0;
        case ({m, cen})
            ADD, SUB: begin
                sum  = full[DIGIT-1:0];
                cout = full[DIGIT];
                // Carry into the MSB falls out of the MSB sum bit: s = a ^ t ^ c.
                cmsb = full[DIGIT-1] ^ a[DIGIT-1] ^ t[DIGIT-1];
            end
            XOR, XNOR: ;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Digit-serial add/sub/xor/xnor unit: DIGIT bits per cycle, LSB slice first,
// with valid/ready handshakes on both sides and a held result in DONE.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    input  logic             Cen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Z,
    output logic             V
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("seq_alu: DIGIT must divide WIDTH and be <= WIDTH");
        end
    endgenerate

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, s_upd;
    logic             m_r, cen_r, carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] sl_sum;
    logic             sl_cout, sl_cmsb;
    logic             accept, last;

    assign in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CW'(NDIG - 1));

    digit_alu #(.DIGIT(DIGIT)) u_dig (
        .a    (a_r[cnt*DIGIT +: DIGIT]),
        .b    (b_r[cnt*DIGIT +: DIGIT]),
        .m    (m_r),
        .cen  (cen_r),
        .cin  (carry),
        .sum  (sl_sum),
        .cout (sl_cout),
        .cmsb (sl_cmsb)
    );

    always_comb begin
        s_upd = S;
        s_upd[cnt*DIGIT +: DIGIT] = sl_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last)   state_nx = DONE;
            // Simultaneous out/in handshake chains straight into the next op.
            DONE:    if (accept) state_nx = RUN;
                     else if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            m_r   <= 1'b0;
            cen_r <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            Z     <= 1'b0;
            V     <= 1'b0;
        end else if (accept) begin
            a_r   <= A;
            b_r   <= B;
            m_r   <= M;
            cen_r <= Cen;
            carry <= M & Cen;
            cnt   <= '0;
        end else if (state == RUN) begin
            S     <= s_upd;
            carry <= sl_cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                Cout <= sl_cout;
                V    <= sl_cmsb ^ sl_cout;
                Z    <= (s_upd == '0);
            end
        end
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter DIGIT, default 4, bits processed per cycle; WIDTH % DIGIT == 0 and DIGIT <= WIDTH; elaboration SHALL fail otherwise.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 M  input  1  mode: 0 add/xor, 1 sub/xnor.
REQ-010 Cen  input  1  carry enable: 1 arithmetic (add/sub), 0 logic (xor/xnor).
REQ-011 out_valid  output  1  result held and valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 S  output  WIDTH  result.
REQ-014 Cout  output  1  final carry; 1 on sub means A >= B unsigned.
REQ-015 Z  output  1  S == 0.
REQ-016 V  output  1  two's-complement overflow.

Function
REQ-017 Operations: M=0,Cen=1 -> A+B; M=1,Cen=1 -> A-B (A + ~B + 1); M=0,Cen=0 -> A^B; M=1,Cen=0 -> ~(A^B).
REQ-018 States: IDLE, RUN, DONE; NDIG = WIDTH/DIGIT.
REQ-019 IDLE: in_ready=1, out_valid=0; in_valid && in_ready on an edge SHALL capture A, B, M, Cen, set carry = M & Cen, digit count = 0, go RUN.
REQ-020 RUN: in_ready=0; each edge processes one DIGIT-bit slice, LSB slice first: T = B_slice ^ {DIGIT{M}}; arithmetic -> slice sum A_slice + T + carry, carry updated; logic -> A_slice ^ T, carry forced 0.
REQ-021 Result slice SHALL be written into S register at slice position; A/B/M/Cen inputs SHALL be ignored in RUN.
REQ-022 On the edge processing slice NDIG-1, state SHALL go DONE; out_valid SHALL be high exactly NDIG cycles after the accepting edge (DIGIT==WIDTH: 1 cycle).
REQ-023 DONE: out_valid=1; S, Cout, Z, V SHALL hold stable until out_valid && out_ready.
REQ-024 DONE: in_ready = out_ready; out and in handshake on same edge SHALL capture new op and go RUN directly (no IDLE bubble); out handshake alone -> IDLE.
REQ-025 Cout = final carry for Cen=1; 0 for Cen=0.
REQ-026 V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 for Cen=1; 0 for Cen=0.
REQ-027 Z = (S == 0) for all operations, valid whenever out_valid=1.
REQ-028 Carry and flags SHALL be computed from captured operands only; no combinational path from A/B to S/flags.

Reset
REQ-029 rst high SHALL immediately force state IDLE, S=0, Cout=0, Z=0, V=0, out_valid=0, carry=0, count=0; in_ready SHALL be 0 while rst is high.
REQ-030 rst mid-RUN or in DONE SHALL abort the operation; no out_valid SHALL appear for it; in_ready=1 in first cycle after release.

Structure
REQ-031 Shared package seq_alu_pkg SHALL hold the state enum (IDLE/RUN/DONE) and op-decode constants (ADD, SUB, XOR, XNOR as {M,Cen}).
REQ-032 One sub-module digit_alu (DIGIT-wide combinational slice: A_slice, B_slice, M, Cen, cin -> sum, cout, carry into MSB) SHALL be instantiated once and reused each cycle.
REQ-033 Counter width SHALL be $clog2(NDIG) with minimum 1.

Verification (WIDTH=8, DIGIT=4)
REQ-034 Add A=0x7F, B=0x01, M=0, Cen=1 -> S=0x80, Cout=0, V=1, Z=0; out_valid 2 cycles after accept.
REQ-035 Sub A=0x05, B=0x07, M=1, Cen=1 -> S=0xFE, Cout=0, V=0, Z=0; then A=0x33, B=0x33 -> S=0x00, Cout=1, Z=1, V=0.
REQ-036 Xnor A=0xF0, B=0xAA, M=1, Cen=0 -> S=0xA5, Cout=0, V=0; xor same operands -> S=0x5A.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted that edge, next out_valid 2 cycles later.
REQ-038 Assert rst one cycle after accept (mid-RUN) -> out_valid stays 0, all outputs 0, in_ready=1 first cycle after release; subsequent add 0x01+0x01 -> S=0x02.
